tetris_input: RTL and testbench
===============================

TETRIS_INPUT -- requirements
Module: tetris_input

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive clocks the synchronized level must differ before the debounced level changes (min 2).
REQ-002 Parameter REPEAT_DELAY, default 15000000, clocks from first move pulse to first auto-repeat pulse (min 2).
REQ-003 Parameter REPEAT_RATE, default 5000000, clocks between successive auto-repeat pulses (min 2).
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btnR  input  1  raw, asynchronous, bouncing right push-button (1 = pressed).
REQ-007 btnL  input  1  raw, asynchronous, bouncing left push-button (1 = pressed).
REQ-008 moveR  output  1  registered single-cycle move-right request to tetris_logic.
REQ-009 moveL  output  1  registered single-cycle move-left request to tetris_logic.

Function
REQ-010 Each button SHALL pass through its own 2-flop synchronizer; no other logic reads btnR/btnL directly.
REQ-011 Per button, a debounce counter SHALL increment each cycle the synchronized level differs from the debounced level, and clear to 0 on any cycle they match.
REQ-012 When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level SHALL toggle on that edge and the counter SHALL clear.
REQ-013 Latency: if edge N is the first edge sampling a stable raw high, debounced goes 1 at edge N+DEBOUNCE_CYCLES+1 and move asserts at edge N+DEBOUNCE_CYCLES+2.
REQ-014 Bounces shorter than DEBOUNCE_CYCLES clocks SHALL produce no debounced change and no pulse.
REQ-015 Per-button FSM states: IDLE, FIRST, REPEAT, BLOCKED; repeat counter width = clog2(max(REPEAT_DELAY,REPEAT_RATE)).
REQ-016 IDLE: on debounced rising edge with the other button's debounced level 0, assert move for one cycle, load repeat counter, go FIRST.
REQ-017 FIRST: after REPEAT_DELAY clocks from the first pulse with the button still held, emit one pulse, go REPEAT.
REQ-018 REPEAT: emit one pulse every REPEAT_RATE clocks while held.
REQ-019 FIRST/REPEAT: debounced release SHALL return to IDLE on the next edge with no pulse.
REQ-020 Any state: when both debounced levels are 1, both FSMs SHALL go BLOCKED and neither output pulses.
REQ-021 BLOCKED: leave for IDLE only when that button's debounced level is 0; a button still held after the other is released SHALL NOT fire until re-pressed.
REQ-022 Simultaneous debounced rising edges on both buttons SHALL produce no pulse; both go BLOCKED.
REQ-023 moveR and moveL SHALL never both be 1 in the same cycle, and each pulse SHALL be exactly one cycle wide.
REQ-024 Repeat counters SHALL never wrap: each counter is reloaded on every pulse and held at 0 in IDLE/BLOCKED.

Reset
REQ-025 While reset=1: synchronizers, debounced levels, debounce counters and repeat counters SHALL be 0, FSMs IDLE, and moveR=moveL=0 on the next edge.
REQ-026 Reset asserted mid-hold or mid-debounce SHALL abort with no pulse.
REQ-027 A button held through reset release SHALL be treated as a new press: exactly one pulse at DEBOUNCE_CYCLES+2 edges after the first post-reset edge, then repeats per REQ-017/018.

Verification (bench overrides DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8)
REQ-028 Clean press of btnR held 40 clocks, first sampled at edge 10 -> moveR pulses at edges 16, 36 and 44 (inside hold window); moveL stays 0.
REQ-029 btnL toggling with 3-clock highs and lows for 30 clocks, then low -> moveL never asserts.
REQ-030 btnL pressed 2 clocks before btnR, both then held 50 clocks -> at most one moveL pulse before BLOCKED, no moveR pulse, no repeats.
REQ-031 Release btnL while btnR is still held -> no moveR pulse; release btnR, re-press it -> moveR pulses DEBOUNCE_CYCLES+2 edges after the re-press.
REQ-032 reset pulsed at edge 25 during the REQ-028 hold -> no pulse at edge 36; next pulse 6 edges after reset deasserts.
REQ-033 Random bouncing on both buttons for 10k cycles -> moveR&moveL never both 1, every pulse is 1 cycle wide.

Source files
------------

// File: rtl/tetris_input.sv
// Left/right push-button front end for the Tetris game: per-button synchronizer
// and debouncer, then a press/auto-repeat FSM that emits single-cycle move requests.
module tetris_input #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 15000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btnR,
    input  logic btnL,
    output logic moveR,
    output logic moveL
);

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(REP_MAX);
    localparam int DW      = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        REPEAT,
        BLOCKED
    } state_t;

    // Channel 0 is the right button, channel 1 the left one.
    logic [1:0] btn;
    logic [1:0] deb_level;
    logic [1:0] move_level;
    logic       both_held;

    assign btn       = {btnL, btnR};
    assign both_held = deb_level[0] & deb_level[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic          sync1_reg;
            logic          sync2_reg;
            logic [DW-1:0] db_cnt_reg;
            logic          deb_reg;
            logic          deb_prev_reg;
            logic          move_reg;
            logic [RW-1:0] rep_cnt_reg;
            state_t        state_reg;

            assign deb_level[gi]  = deb_reg;
            assign move_level[gi] = move_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_reg    <= 1'b0;
                    sync2_reg    <= 1'b0;
                    db_cnt_reg   <= '0;
                    deb_reg      <= 1'b0;
                    deb_prev_reg <= 1'b0;
                    move_reg     <= 1'b0;
                    rep_cnt_reg  <= '0;
                    state_reg    <= IDLE;
                end else begin
                    sync1_reg    <= btn[gi];
                    sync2_reg    <= sync1_reg;
                    deb_prev_reg <= deb_reg;
                    move_reg     <= 1'b0;

                    // Debounced level only follows after DEBOUNCE_CYCLES consecutive disagreements.
                    if (sync2_reg != deb_reg) begin
                        if (db_cnt_reg == DW'(DEBOUNCE_CYCLES - 1)) begin
                            deb_reg    <= sync2_reg;
                            db_cnt_reg <= '0;
                        end else begin
                            db_cnt_reg <= db_cnt_reg + DW'(1);
                        end
                    end else begin
                        db_cnt_reg <= '0;
                    end

                    if (both_held) begin
                        state_reg   <= BLOCKED;
                        rep_cnt_reg <= '0;
                    end else begin
                        case (state_reg)
                            IDLE: begin
                                rep_cnt_reg <= '0;
                                if (deb_reg && !deb_prev_reg && !deb_level[1-gi]) begin
                                    move_reg    <= 1'b1;
                                    rep_cnt_reg <= RW'(REPEAT_DELAY - 1);
                                    state_reg   <= FIRST;
                                end
                            end
                            FIRST, REPEAT: begin
                                if (!deb_reg) begin
                                    rep_cnt_reg <= '0;
                                    state_reg   <= IDLE;
                                end else if (rep_cnt_reg == '0) begin
                                    move_reg    <= 1'b1;
                                    rep_cnt_reg <= RW'(REPEAT_RATE - 1);
                                    state_reg   <= REPEAT;
                                end else begin
                                    rep_cnt_reg <= rep_cnt_reg - RW'(1);
                                end
                            end
                            BLOCKED: begin
                                // Held buttons must be released before they can fire again.
                                rep_cnt_reg <= '0;
                                if (!deb_reg) begin
                                    state_reg <= IDLE;
                                end
                            end
                            default: begin
                                rep_cnt_reg <= '0;
                                state_reg   <= IDLE;
                            end
                        endcase
                    end
                end
            end
        end
    endgenerate

    assign moveR = move_level[0];
    assign moveL = move_level[1];

endmodule

// File: tb/tb_tetris_input.sv
// Scoreboard bench for tetris_input: expected pulse edges are queued with the
// stimulus and matched against the edges where moveR/moveL actually fire.
module tb_tetris_input;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btnR = 1'b0;
    logic btnL = 1'b0;
    logic moveR;
    logic moveL;

    tetris_input #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_RATE    (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .btnR (btnR),
        .btnL (btnL),
        .moveR(moveR),
        .moveL(moveL)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int base = 0;
    int n_r = 0;
    int n_l = 0;
    int exp_r[$];
    int exp_l[$];
    logic free_run = 1'b0;
    logic prev_r = 1'b0;
    logic prev_l = 1'b0;

    // After posedge number k, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cyc=%0d)", tag, obs, exp, cyc);
        end
    endtask

    // Outputs are sampled on the falling edge following the edge that set them.
    always @(negedge clk) begin
        if (moveR || moveL) begin
            $display("cyc=%0d rel=%0d moveR=%0b moveL=%0b", cyc, cyc - base, moveR, moveL);
            check_val("mutex", int'(moveR & moveL), 0);
        end
        if (moveR) begin
            n_r <= n_r + 1;
            check_val("width_r", int'(prev_r), 0);
            if (!free_run) begin
                if (exp_r.size() == 0) check_val("unexp_moveR", cyc - base, -1);
                else check_val("moveR_edge", cyc, exp_r.pop_front());
            end
        end
        if (moveL) begin
            n_l <= n_l + 1;
            check_val("width_l", int'(prev_l), 0);
            if (!free_run) begin
                if (exp_l.size() == 0) check_val("unexp_moveL", cyc - base, -1);
                else check_val("moveL_edge", cyc, exp_l.pop_front());
            end
        end
        prev_r <= moveR;
        prev_l <= moveL;
    end

    // Returns on the falling edge after edge e; inputs set then are first sampled at e+1.
    task automatic wait_edge(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        btnR  = 1'b0;
        btnL  = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_moveR", int'(moveR), 0);
        check_val("rst_moveL", int'(moveL), 0);
        reset = 1'b0;
        base  = cyc;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        int l0;
        logic tgt_r;
        logic tgt_l;

        // Clean right press, raw high sampled at edges 10..49.
        do_reset();
        exp_r.push_back(base + 16);
        exp_r.push_back(base + 36);
        exp_r.push_back(base + 44);
        exp_r.push_back(base + 52);  // debounced level still high until edge 55
        wait_edge(base + 9);  btnR = 1'b1;
        wait_edge(base + 49); btnR = 1'b0;
        wait_edge(base + 80);
        check_val("s1_pending_r", exp_r.size(), 0);

        // Short left bounces never reach the debounce threshold.
        do_reset();
        l0 = n_l;
        wait_edge(base + 9);
        for (int k = 0; k < 5; k++) begin
            btnL = 1'b1;
            repeat (3) @(negedge clk);
            btnL = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check_val("s2_moveL_count", n_l - l0, 0);

        // Left then right held together, release left, then release and re-press right.
        do_reset();
        r0 = n_r;
        l0 = n_l;
        exp_l.push_back(base + 16);
        exp_r.push_back(base + 106);
        wait_edge(base + 9);   btnL = 1'b1;
        wait_edge(base + 11);  btnR = 1'b1;
        wait_edge(base + 59);  btnL = 1'b0;
        wait_edge(base + 79);
        check_val("s3_blocked_r", n_r - r0, 0);
        btnR = 1'b0;
        wait_edge(base + 99);  btnR = 1'b1;
        wait_edge(base + 109); btnR = 1'b0;
        wait_edge(base + 140);
        check_val("s3_pending_r", exp_r.size(), 0);
        check_val("s3_pending_l", exp_l.size(), 0);
        check_val("s3_count_l", n_l - l0, 1);
        check_val("s3_count_r", n_r - r0, 1);

        // Reset pulse at edge 25 during the hold restarts the press.
        do_reset();
        exp_r.push_back(base + 16);
        exp_r.push_back(base + 32);
        exp_r.push_back(base + 52);
        wait_edge(base + 9);  btnR = 1'b1;
        wait_edge(base + 24); reset = 1'b1;
        wait_edge(base + 25); reset = 1'b0;
        check_val("s4_rst_moveR", int'(moveR), 0);
        wait_edge(base + 49); btnR = 1'b0;
        wait_edge(base + 80);
        check_val("s4_pending_r", exp_r.size(), 0);

        // Random bouncing on both buttons; only exclusivity and pulse width are judged.
        do_reset();
        r0 = n_r;
        l0 = n_l;
        free_run = 1'b1;
        tgt_r = 1'b0;
        tgt_l = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 15) == 0) tgt_r = ~tgt_r;
            if ($urandom_range(0, 15) == 0) tgt_l = ~tgt_l;
            btnR = tgt_r ^ ($urandom_range(0, 7) == 0);
            btnL = tgt_l ^ ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        btnR = 1'b0;
        btnL = 1'b0;
        repeat (30) @(negedge clk);
        free_run = 1'b0;
        check_val("s5_activity", int'((n_r - r0 + n_l - l0) > 0), 1);
        repeat (20) @(negedge clk);
        check_val("s5_quiet_r", exp_r.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
